cmd_dispatch: RTL and testbench
===============================

Name: cmd_dispatch

Overview:
- Parametrised successor of the oscilloscope command configuration block. It takes 24-bit host commands from the UART command receiver, decodes them, and keeps the acquisition configuration registers (decimator, trigger position, trigger config, per-channel gain).
- It runs SPI transactions to the AFE/trigger DACs and the calibration EEPROM, and waits for each to complete.
- It returns exactly one response byte per command (ACK, NAK or read data) through the send_resp/resp_sent handshake.

Parameters:
NUM_CH, 3, number of analog channels (1..4); channel field cc is 2 bits, cc>=NUM_CH is invalid
DEC_W, 4, decimator width (1..8), taken from cmd[DEC_W-1:0]
TPOS_W, 9, trigger-position width (1..16), taken from cmd[TPOS_W-1:0]
TRIG_MIN, 46, lower saturation bound for trigger level
TRIG_MAX, 201, upper saturation bound for trigger level
SS_TRIG, 3, ss code for trigger-level DAC
SS_EEP, 4, ss code for calibration EEPROM

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd  in  24  opcode[23:16], byte2[15:8], byte3[7:0]
cmd_rdy  in  1  command valid from UART receiver
clr_cmd_rdy  out  1  one-cycle pulse, consumes cmd
wrt_SPI  out  1  one-cycle SPI start pulse
ss  out  3  slave select code; 3'b111 = none
SPI_data  out  16  SPI transmit word
SPI_done  in  1  SPI transaction complete (one-cycle pulse)
EEP_data  in  8  EEPROM read byte, valid with SPI_done
dump_en  out  1  one-cycle dump start
dump_chan  out  2  channel to dump
dump_done  in  1  dump finished pulse
set_capture_done  in  1  capture engine sets trig_cfg[5]
resp_data  out  8  response byte
send_resp  out  1  one-cycle response request
resp_sent  in  1  response transmitted pulse
decimator  out  DEC_W  decimator register
trig_pos  out  TPOS_W  trigger position register
trig_cfg  out  6  trigger config {d,e,tt,cc}
gain  out  3*NUM_CH  packed per-channel gain, ch0 in [2:0]

Behaviour:
- Reset: state IDLE. All pulse outputs 0, ss=3'b111, SPI_data=0, resp_data=0, dump_chan=0. decimator, trig_pos, trig_cfg and gain are all 0. Reset mid-command abandons it; no response is sent.
- All outputs are registered.
- States: IDLE, DECODE, SPI_WAIT, DUMP_WAIT, RESP, RESP_WAIT.
- IDLE: cmd_rdy=1 at cycle N latches cmd; state goes to DECODE. cmd_rdy is ignored in every state other than IDLE.
- DECODE (cycle N+1): clr_cmd_rdy=1 for this cycle only. The opcode is compared exactly on all 8 bits (no don't-cares):
  - 01 dump: if cc<NUM_CH, dump_en pulse, dump_chan=cc, go to DUMP_WAIT; else NAK.
  - 02 gain: valid cc sets gain[cc]=cmd[12:10], ss=cc, SPI_data={8'h13,GAIN_TBL[ggg]}, wrt_SPI pulse, go to SPI_WAIT; invalid cc gives NAK.
  - 03 trig level: ss=SS_TRIG, SPI_data={8'h13,sat(LL)}, where sat clamps LL to [TRIG_MIN,TRIG_MAX] inclusive; go to SPI_WAIT.
  - 04: trig_pos updated; ACK.
  - 05: decimator updated; ACK.
  - 06: trig_cfg=cmd[13:8]; ACK.
  - 07: resp_data={2'b00,trig_cfg}.
  - 08 EEP write: ss=SS_EEP, SPI_data={2'b01,cmd[13:0]}, go to SPI_WAIT.
  - 09 EEP read: ss=SS_EEP, SPI_data={2'b00,cmd[13:8],8'h00}, go to SPI_WAIT.
  - Any other opcode: NAK.
- Register writes take effect at the end of the DECODE cycle.
- SPI_WAIT: ss and SPI_data are held. On SPI_done: ss=3'b111; resp_data=EEP_data for opcode 09, else ACK; go to RESP. There is no timeout.
- DUMP_WAIT: on dump_done, resp_data=ACK, go to RESP.
- RESP: send_resp pulses for 1 cycle, then RESP_WAIT. On resp_sent, go to IDLE.
- Latency:
  - Register command: send_resp at N+2.
  - SPI command: send_resp 1 cycle after SPI_done.
- Response codes: ACK=8'hA5, NAK=8'hEE.
- trig_cfg[5]: set_capture_done sets it. A same-cycle 06 write is applied first, then the set (the set wins on bit 5).
- Back-to-back commands: the next cmd_rdy is sampled only after returning to IDLE. Minimum spacing is 4 cycles plus resp_sent delay.

Optional Feature:
CMD_RDBK_EN:
- Defined: opcode 0A returns {5'b0,gain[cc]}, or NAK if cc is invalid. Opcode 0B returns decimator zero-extended (truncated to 8 bits if DEC_W>8). Opcode 0C returns trig_pos[7:0].
- Undefined: 0A/0B/0C give NAK, and no readback mux is synthesised.

Decomposition:
- Package cmd_pkg holds:
  - opcode localparams;
  - ACK/NAK constants;
  - GAIN_TBL (8x8: 02,05,09,14,28,46,6B,DD);
  - the state enum;
  - SPI prefix 8'h13.
- One sub-module, trig_sat, contains the parametrised saturating clamp for trigger level (combinational, TRIG_MIN/TRIG_MAX).

Test Plan:
- cmd=24'h02_0E_00 (ch2, ggg=3) then SPI_done after 20 cycles -> wrt_SPI once, ss=2, SPI_data=16'h1314, gain[8:6]=3, resp_data=A5; ss=3'b111 after SPI_done.
- cmd 03_xx_10 / 03_xx_FF / 03_xx_80 -> SPI_data 132E / 13C9 / 1380, ss=3.
- cmd 09_05_xx, EEP_data=8'h7C at SPI_done -> SPI_data=16'h0500, ss=4, resp_data=7C.
- cmd 01_03_xx with NUM_CH=3 -> no dump_en, NAK EE; cmd 01_01_xx, dump_done later -> dump_chan=1, ACK.
- cmd 06_3F_xx with set_capture_done in the same DECODE cycle -> trig_cfg=6'h3F. Then 06_05_xx -> 6'h05, and 07 returns 8'h05. Opcode 8'h11 -> NAK; opcode 8'h0A -> NAK unless CMD_RDBK_EN is defined.
- rst asserted during SPI_WAIT -> next cycle IDLE, ss=111, all registers 0, no send_resp. Also check that clr_cmd_rdy pulses exactly once per command.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared opcodes, response codes, gain DAC table and FSM states for cmd_dispatch.
package cmd_pkg;

    localparam logic [7:0] OP_DUMP    = 8'h01;
    localparam logic [7:0] OP_GAIN    = 8'h02;
    localparam logic [7:0] OP_TRIG    = 8'h03;
    localparam logic [7:0] OP_TPOS    = 8'h04;
    localparam logic [7:0] OP_DEC     = 8'h05;
    localparam logic [7:0] OP_TCFG_WR = 8'h06;
    localparam logic [7:0] OP_TCFG_RD = 8'h07;
    localparam logic [7:0] OP_EEP_WR  = 8'h08;
    localparam logic [7:0] OP_EEP_RD  = 8'h09;
    localparam logic [7:0] OP_RD_GAIN = 8'h0A;
    localparam logic [7:0] OP_RD_DEC  = 8'h0B;
    localparam logic [7:0] OP_RD_TPOS = 8'h0C;

    localparam logic [7:0] ACK     = 8'hA5;
    localparam logic [7:0] NAK     = 8'hEE;
    localparam logic [7:0] SPI_PFX = 8'h13;
    localparam logic [2:0] SS_NONE = 3'b111;

    // Entry [i] is the AFE DAC code for gain setting i.
    localparam logic [7:0][7:0] GAIN_TBL = {8'hDD, 8'h6B, 8'h46, 8'h28,
                                            8'h14, 8'h09, 8'h05, 8'h02};

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        SPI_WAIT,
        DUMP_WAIT,
        RESP,
        RESP_WAIT
    } state_t;

endpackage

// File: rtl/trig_sat.sv
// Saturating clamp of the 8-bit trigger level into [TRIG_MIN, TRIG_MAX].
module trig_sat #(
    parameter int TRIG_MIN = 46,
    parameter int TRIG_MAX = 201
) (
    input  logic [7:0] lvl,
    output logic [7:0] lvl_sat
);

    localparam logic [7:0] LO = 8'(TRIG_MIN);
    localparam logic [7:0] HI = 8'(TRIG_MAX);

    always_comb begin
        lvl_sat = lvl;
        if (lvl < LO)
            lvl_sat = LO;
        else if (lvl > HI)
            lvl_sat = HI;
    end

endmodule

// File: rtl/cmd_dispatch.sv
// Host command decoder: holds acquisition config, runs SPI/dump transactions, returns one response per command.
// Optional register readback (opcodes 0A/0B/0C) is enabled by defining CMD_RDBK_EN.
module cmd_dispatch #(
    parameter int NUM_CH   = 3,
    parameter int DEC_W    = 4,
    parameter int TPOS_W   = 9,
    parameter int TRIG_MIN = 46,
    parameter int TRIG_MAX = 201,
    parameter int SS_TRIG  = 3,
    parameter int SS_EEP   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [23:0]           cmd,
    input  logic                  cmd_rdy,
    output logic                  clr_cmd_rdy,
    output logic                  wrt_SPI,
    output logic [2:0]            ss,
    output logic [15:0]           SPI_data,
    input  logic                  SPI_done,
    input  logic [7:0]            EEP_data,
    output logic                  dump_en,
    output logic [1:0]            dump_chan,
    input  logic                  dump_done,
    input  logic                  set_capture_done,
    output logic [7:0]            resp_data,
    output logic                  send_resp,
    input  logic                  resp_sent,
    output logic [DEC_W-1:0]      decimator,
    output logic [TPOS_W-1:0]     trig_pos,
    output logic [5:0]            trig_cfg,
    output logic [3*NUM_CH-1:0]   gain
);

    import cmd_pkg::*;

    state_t                  state;
    logic [23:0]             cmd_q;
    logic [NUM_CH-1:0][2:0]  gain_r;

    logic [7:0] op;
    logic [1:0] cc;
    logic [2:0] ggg;
    logic       cc_ok;
    logic [7:0] lvl_sat;
    logic       unused_cmd_bits;

    assign op    = cmd_q[23:16];
    assign cc    = cmd_q[9:8];
    assign ggg   = cmd_q[12:10];
    assign cc_ok = (int'(cc) < NUM_CH);
    assign gain  = gain_r;
    assign unused_cmd_bits = ^cmd_q[15:14];

    trig_sat #(
        .TRIG_MIN (TRIG_MIN),
        .TRIG_MAX (TRIG_MAX)
    ) u_trig_sat (
        .lvl     (cmd_q[7:0]),
        .lvl_sat (lvl_sat)
    );

`ifdef CMD_RDBK_EN
    logic [2:0] gain_rd;

    always_comb begin
        gain_rd = 3'd0;
        for (int i = 0; i < NUM_CH; i++)
            if (cc == 2'(i))
                gain_rd = gain_r[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            clr_cmd_rdy <= 1'b0;
            wrt_SPI     <= 1'b0;
            ss          <= SS_NONE;
            SPI_data    <= '0;
            dump_en     <= 1'b0;
            dump_chan   <= '0;
            resp_data   <= '0;
            send_resp   <= 1'b0;
            decimator   <= '0;
            trig_pos    <= '0;
            trig_cfg    <= '0;
            gain_r      <= '0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            wrt_SPI     <= 1'b0;
            dump_en     <= 1'b0;
            send_resp   <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        cmd_q       <= cmd;
                        clr_cmd_rdy <= 1'b1;
                        state       <= DECODE;
                    end
                end

                DECODE: begin
                    // Register-style commands respond immediately; the SPI and
                    // dump paths below override this and wait for completion.
                    resp_data <= ACK;
                    send_resp <= 1'b1;
                    state     <= RESP;
                    case (op)
                        OP_DUMP: begin
                            if (cc_ok) begin
                                dump_en   <= 1'b1;
                                dump_chan <= cc;
                                send_resp <= 1'b0;
                                state     <= DUMP_WAIT;
                            end else
                                resp_data <= NAK;
                        end
                        OP_GAIN: begin
                            if (cc_ok) begin
                                for (int i = 0; i < NUM_CH; i++)
                                    if (cc == 2'(i))
                                        gain_r[i] <= ggg;
                                ss        <= {1'b0, cc};
                                SPI_data  <= {SPI_PFX, GAIN_TBL[ggg]};
                                wrt_SPI   <= 1'b1;
                                send_resp <= 1'b0;
                                state     <= SPI_WAIT;
                            end else
                                resp_data <= NAK;
                        end
                        OP_TRIG: begin
                            ss        <= 3'(SS_TRIG);
                            SPI_data  <= {SPI_PFX, lvl_sat};
                            wrt_SPI   <= 1'b1;
                            send_resp <= 1'b0;
                            state     <= SPI_WAIT;
                        end
                        OP_TPOS:    trig_pos  <= cmd_q[TPOS_W-1:0];
                        OP_DEC:     decimator <= cmd_q[DEC_W-1:0];
                        OP_TCFG_WR: trig_cfg  <= cmd_q[13:8];
                        OP_TCFG_RD: resp_data <= {2'b00, trig_cfg};
                        OP_EEP_WR: begin
                            ss        <= 3'(SS_EEP);
                            SPI_data  <= {2'b01, cmd_q[13:0]};
                            wrt_SPI   <= 1'b1;
                            send_resp <= 1'b0;
                            state     <= SPI_WAIT;
                        end
                        OP_EEP_RD: begin
                            ss        <= 3'(SS_EEP);
                            SPI_data  <= {2'b00, cmd_q[13:8], 8'h00};
                            wrt_SPI   <= 1'b1;
                            send_resp <= 1'b0;
                            state     <= SPI_WAIT;
                        end
`ifdef CMD_RDBK_EN
                        OP_RD_GAIN: resp_data <= cc_ok ? {5'b0, gain_rd} : NAK;
                        OP_RD_DEC:  resp_data <= 8'(decimator);
                        OP_RD_TPOS: resp_data <= 8'(trig_pos);
`else
                        OP_RD_GAIN, OP_RD_DEC, OP_RD_TPOS: resp_data <= NAK;
`endif
                        default:    resp_data <= NAK;
                    endcase
                end

                SPI_WAIT: begin
                    if (SPI_done) begin
                        ss        <= SS_NONE;
                        resp_data <= (op == OP_EEP_RD) ? EEP_data : ACK;
                        send_resp <= 1'b1;
                        state     <= RESP;
                    end
                end

                DUMP_WAIT: begin
                    if (dump_done) begin
                        resp_data <= ACK;
                        send_resp <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP:      state <= RESP_WAIT;

                RESP_WAIT: if (resp_sent) state <= IDLE;

                default:   state <= IDLE;
            endcase

            // Placed after the decode so a same-cycle trig_cfg write loses bit 5.
            if (set_capture_done)
                trig_cfg[5] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Randomised self-checking bench for cmd_dispatch against a command-level reference model.
module tb_cmd_dispatch;

    localparam int NCH    = 3;
    localparam int K_REG  = 0;
    localparam int K_SPI  = 1;
    localparam int K_DUMP = 2;
    localparam int ACKV   = 'hA5;
    localparam int NAKV   = 'hEE;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        wrt_SPI;
    logic [2:0]  ss;
    logic [15:0] SPI_data;
    logic        SPI_done;
    logic [7:0]  EEP_data;
    logic        dump_en;
    logic [1:0]  dump_chan;
    logic        dump_done;
    logic        set_capture_done;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic [3:0]  decimator;
    logic [8:0]  trig_pos;
    logic [5:0]  trig_cfg;
    logic [8:0]  gain;

    cmd_dispatch dut (
        .clk              (clk),
        .rst              (rst),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .wrt_SPI          (wrt_SPI),
        .ss               (ss),
        .SPI_data         (SPI_data),
        .SPI_done         (SPI_done),
        .EEP_data         (EEP_data),
        .dump_en          (dump_en),
        .dump_chan        (dump_chan),
        .dump_done        (dump_done),
        .set_capture_done (set_capture_done),
        .resp_data        (resp_data),
        .send_resp        (send_resp),
        .resp_sent        (resp_sent),
        .decimator        (decimator),
        .trig_pos         (trig_pos),
        .trig_cfg         (trig_cfg),
        .gain             (gain)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_clr, n_wrt, n_dump, n_send;

    // reference model state
    int m_dec, m_tpos, m_cfg;
    int m_gain [NCH];
    int gtbl [8] = '{2, 5, 9, 20, 40, 70, 107, 221};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        n_clr  += int'(clr_cmd_rdy);
        n_wrt  += int'(wrt_SPI);
        n_dump += int'(dump_en);
        n_send += int'(send_resp);
    endtask

    task automatic clr_cnt();
        n_clr = 0; n_wrt = 0; n_dump = 0; n_send = 0;
    endtask

    task automatic model_reset();
        m_dec = 0; m_tpos = 0; m_cfg = 0;
        for (int i = 0; i < NCH; i++) m_gain[i] = 0;
    endtask

    function automatic int sat(input int l);
        if (l < 46) return 46;
        if (l > 201) return 201;
        return l;
    endfunction

    function automatic int model_gain();
        int g = 0;
        for (int i = 0; i < NCH; i++) g += m_gain[i] << (3 * i);
        return g;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".dec"},  decimator, m_dec);
        chk({tag, ".tpos"}, trig_pos,  m_tpos);
        chk({tag, ".cfg"},  trig_cfg,  m_cfg);
        chk({tag, ".gain"}, gain,      model_gain());
    endtask

    // Issue one command, play the SPI/dump/UART partners, compare against the model.
    task automatic do_cmd(input logic [23:0] c, input int lat, input logic [7:0] eep, input bit cap);
        int op, b2, cc, ggg, kind, e_ss, e_spi, e_resp;
        op   = int'(c[23:16]);
        b2   = int'(c[15:8]);
        cc   = b2 % 4;
        ggg  = (b2 / 4) % 8;
        kind = K_REG; e_resp = ACKV; e_ss = 7; e_spi = 0;
        case (op)
            1: if (cc < NCH) kind = K_DUMP; else e_resp = NAKV;
            2: if (cc < NCH) begin
                   kind = K_SPI; e_ss = cc; e_spi = 'h1300 + gtbl[ggg]; m_gain[cc] = ggg;
               end else e_resp = NAKV;
            3: begin kind = K_SPI; e_ss = 3; e_spi = 'h1300 + sat(int'(c[7:0])); end
            4: m_tpos = int'(c) % 512;
            5: m_dec  = int'(c) % 16;
            6: m_cfg  = b2 % 64;
            7: e_resp = m_cfg;
            8: begin kind = K_SPI; e_ss = 4; e_spi = 'h4000 + int'(c) % 'h4000; end
            9: begin kind = K_SPI; e_ss = 4; e_spi = (b2 % 64) * 256; e_resp = int'(eep); end
`ifdef CMD_RDBK_EN
            10: e_resp = (cc < NCH) ? m_gain[cc] : NAKV;
            11: e_resp = m_dec;
            12: e_resp = m_tpos % 256;
`endif
            default: e_resp = NAKV;
        endcase
        if (cap) m_cfg = m_cfg | 32;

        clr_cnt();
        cmd = c; cmd_rdy = 1'b1;
        tick();
        chk("clr_cmd_rdy", clr_cmd_rdy, 1);
        cmd_rdy = 1'b0; set_capture_done = cap;
        tick();
        set_capture_done = 1'b0;
        if (kind == K_SPI) begin
            chk("wrt_SPI", wrt_SPI, 1);
            chk("ss", ss, e_ss);
            chk("SPI_data", SPI_data, e_spi);
            repeat (lat) tick();
            chk("ss_hold", ss, e_ss);
            chk("SPI_data_hold", SPI_data, e_spi);
            SPI_done = 1'b1; EEP_data = eep;
            tick();
            SPI_done = 1'b0; EEP_data = 8'($urandom);
            chk("ss_release", ss, 7);
        end else if (kind == K_DUMP) begin
            chk("dump_en", dump_en, 1);
            chk("dump_chan", dump_chan, cc);
            repeat (lat) tick();
            dump_done = 1'b1;
            tick();
            dump_done = 1'b0;
        end
        chk("send_resp", send_resp, 1);
        chk("resp_data", resp_data, e_resp);
        tick(); tick();
        resp_sent = 1'b1;
        tick();
        resp_sent = 1'b0;
        chk("n_clr", n_clr, 1);
        chk("n_send", n_send, 1);
        chk("n_wrt", n_wrt, (kind == K_SPI) ? 1 : 0);
        chk("n_dump", n_dump, (kind == K_DUMP) ? 1 : 0);
        check_regs("regs");
    endtask

    initial begin
        logic [23:0] c;
        int          pick;

        rst = 1'b1; cmd = '0; cmd_rdy = 1'b0; SPI_done = 1'b0; EEP_data = '0;
        dump_done = 1'b0; set_capture_done = 1'b0; resp_sent = 1'b0;
        model_reset();
        clr_cnt();
        tick(); tick();
        chk("rst.ss", ss, 7);
        chk("rst.SPI_data", SPI_data, 0);
        chk("rst.resp_data", resp_data, 0);
        chk("rst.dump_chan", dump_chan, 0);
        chk("rst.pulses", {clr_cmd_rdy, wrt_SPI, dump_en, send_resp}, 0);
        check_regs("rst");
        rst = 1'b0;
        tick();

        // directed
        do_cmd(24'h020E00, 20, 8'h00, 1'b0);
        do_cmd(24'h030010, 3, 8'h00, 1'b0);
        do_cmd(24'h0300FF, 0, 8'h00, 1'b0);
        do_cmd(24'h030080, 1, 8'h00, 1'b0);
        do_cmd(24'h030000, 1, 8'h00, 1'b0);
        do_cmd(24'h0300C9, 1, 8'h00, 1'b0);
        do_cmd(24'h090500, 4, 8'h7C, 1'b0);
        do_cmd(24'h082ABC, 2, 8'h00, 1'b0);
        do_cmd(24'h010300, 0, 8'h00, 1'b0);
        do_cmd(24'h010100, 5, 8'h00, 1'b0);
        do_cmd(24'h063F00, 0, 8'h00, 1'b1);
        do_cmd(24'h060500, 0, 8'h00, 1'b0);
        do_cmd(24'h070000, 0, 8'h00, 1'b0);
        do_cmd(24'h0601FF, 0, 8'h00, 1'b1);
        do_cmd(24'h0401A5, 0, 8'h00, 1'b0);
        do_cmd(24'h05000B, 0, 8'h00, 1'b0);
        do_cmd(24'h021D00, 2, 8'h00, 1'b0);
        do_cmd(24'h110000, 0, 8'h00, 1'b0);
        do_cmd(24'h0A0100, 0, 8'h00, 1'b0);
        do_cmd(24'h0B0000, 0, 8'h00, 1'b0);
        do_cmd(24'h0C0000, 0, 8'h00, 1'b0);
        do_cmd(24'h0A0300, 0, 8'h00, 1'b0);

        // reset while an SPI transaction is outstanding
        clr_cnt();
        cmd = 24'h021500; cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        tick(); tick();
        chk("abort.ss_busy", ss, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("abort.ss", ss, 7);
        chk("abort.SPI_data", SPI_data, 0);
        chk("abort.resp_data", resp_data, 0);
        check_regs("abort");
        SPI_done = 1'b1;
        tick();
        SPI_done = 1'b0;
        repeat (4) tick();
        chk("abort.no_resp", n_send, 0);
        do_cmd(24'h070000, 0, 8'h00, 1'b0);

        // randomised
        for (int i = 0; i < 80; i++) begin
            pick = $urandom_range(0, 13);
            c = 24'($urandom);
            if (pick < 12)
                c[23:16] = 8'(pick + 1);
            else if (pick == 12)
                c[23:16] = 8'h11;
            do_cmd(c, $urandom_range(0, 6), 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
